squeeze_dump_stage: RTL and testbench

Third pipeline stage of the Keccak core, generalised over output word width and hash mode. It accepts permuted rate blocks from the permute stage and serialises them into `W`-bit output words over a valid/ready interface. It tracks the requested output length and asks the permute stage for further squeeze blocks until that length is met. It supports SHAKE128, SHAKE256, SHA3-256 and SHA3-512, with a masked partial final word.

---
 rtl/keccak_pkg.sv | 41 ++++
 rtl/output_shift_buffer.sv | 51 +++++
 rtl/squeeze_dump_stage.sv | 205 ++++++++++++++++++++
 tb/tb_squeeze_dump_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: rate constants, hash mode encoding, fixed
// SHA3 output lengths, FSM state encoding for the squeeze/dump stage,
// and small helpers (rate lookup, saturating subtraction).
package keccak_pkg;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int RATE_SHA3_512 = 576;

    localparam int LEN_SHA3_256 = 256;
    localparam int LEN_SHA3_512 = 512;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'b00,
        MODE_SHAKE256 = 2'b01,
        MODE_SHA3_256 = 2'b10,
        MODE_SHA3_512 = 2'b11
    } keccak_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BLOCK = 2'd1,
        ST_DUMP       = 2'd2
    } dump_state_t;

    // SHA3-256 shares the SHAKE256 rate (capacity 512).
    function automatic logic [31:0] rate_of(input keccak_mode_t mode);
        case (mode)
            MODE_SHAKE128: rate_of = 32'(RATE_SHAKE128);
            MODE_SHAKE256: rate_of = 32'(RATE_SHAKE256);
            MODE_SHA3_256: rate_of = 32'(RATE_SHAKE256);
            default:       rate_of = 32'(RATE_SHA3_512);
        endcase
    endfunction

    // a - min(a, b)
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        sat_sub = (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/output_shift_buffer.sv
// Rate-wide shift buffer that serialises a loaded block W bits at a time.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (counter only)
//   load            capture load_data and set the word count to load_words
//   load_data       block bits to capture
//   load_words      number of W-bit words held after a load
//   shift           drop the low W bits and decrement the word count
//   clear           mark the buffer empty without a load (shadow hand-off)
//   data            current buffer contents, word 0 in the low W bits
//   words           words remaining
//   empty           no words remaining
module output_shift_buffer #(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [RATE_MAX-1:0] load_data,
    input  logic [7:0]          load_words,
    input  logic                shift,
    input  logic                clear,
    output logic [RATE_MAX-1:0] data,
    output logic [7:0]          words,
    output logic                empty
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words <= 8'd0;
        end else if (load) begin
            words <= load_words;
        end else if (clear) begin
            words <= 8'd0;
        end else if (shift && words != 8'd0) begin
            words <= words - 8'd1;
        end
    end

    // Payload needs no reset; the word count alone says what is valid.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= data >> W;
        end
    end

    assign empty = (words == 8'd0);

endmodule

// File: rtl/squeeze_dump_stage.sv
// Keccak squeeze/dump stage: takes permuted rate blocks and streams them out
// as W-bit words (LSB first) over valid/ready, requesting further squeeze
// blocks until the requested output length is met. The final word is masked
// above the remaining bit count.
// Optional build macro SQUEEZE_DUMP_DOUBLE_BUFFER_EN adds a shadow block
// buffer so the next block can be accepted during DUMP, removing the bubble
// between blocks.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, mode_in,
//   output_size_in           job start, hash mode, requested length in bits
//   block_in, block_valid,
//   block_ready              rate block input handshake
//   need_block               more blocks are still required
//   data_out, valid_out,
//   ready_in, last_out       output word stream
//   busy, done               job active, one-cycle end-of-job pulse
module squeeze_dump_stage
    import keccak_pkg::*;
#(
    parameter int W        = 64,
    parameter int RATE_MAX = RATE_SHAKE128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode_in,
    input  logic [31:0]         output_size_in,
    input  logic [RATE_MAX-1:0] block_in,
    input  logic                block_valid,
    output logic                block_ready,
    output logic                need_block,
    output logic [W-1:0]        data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                last_out,
    output logic                busy,
    output logic                done
);

    dump_state_t         state;
    keccak_mode_t        mode;
    logic [31:0]         bits_to_load;
    logic [31:0]         bits_to_emit;
    logic [31:0]         rate;
    logic [7:0]          blk_words;
    logic [31:0]         start_size;
    logic                fire;
    logic                blk_fire;
    logic                final_word;
    logic                main_load;
    logic [RATE_MAX-1:0] main_src;
    logic [7:0]          main_src_words;
    logic [RATE_MAX-1:0] main_data;
    logic [7:0]          main_words;
    logic                main_empty;

    // Zero every bit at index >= n (only when n < W).
    function automatic logic [W-1:0] mask_tail(input logic [W-1:0] d, input logic [31:0] n);
        logic [W-1:0] m;
        m = '1;
        if (n < 32'(W)) begin
            m = m >> (32'(W) - n);
        end
        return d & m;
    endfunction

    assign rate       = rate_of(mode);
    assign blk_words  = 8'(rate / 32'(W));
    assign busy       = (state != ST_IDLE);
    assign need_block = busy && (bits_to_load != 32'd0);
    assign valid_out  = (state == ST_DUMP) && !main_empty;
    assign final_word = (bits_to_emit <= 32'(W));
    assign last_out   = valid_out && final_word;
    assign data_out   = valid_out ? mask_tail(main_data[W-1:0], bits_to_emit) : '0;
    assign fire       = valid_out && ready_in;
    assign blk_fire   = block_valid && block_ready;

    always_comb begin
        case (mode_in)
            2'b10:   start_size = 32'(LEN_SHA3_256);
            2'b11:   start_size = 32'(LEN_SHA3_512);
            default: start_size = output_size_in;
        endcase
    end

`ifdef SQUEEZE_DUMP_DOUBLE_BUFFER_EN
    logic                shadow_load;
    logic                shadow_clear;
    logic                exhaust;
    logic [RATE_MAX-1:0] shadow_data;
    logic [7:0]          shadow_words;
    logic                shadow_empty;

    assign exhaust     = fire && !final_word && (main_words == 8'd1);
    assign block_ready = (state == ST_WAIT_BLOCK) ||
                         ((state == ST_DUMP) && shadow_empty && need_block);

    // On the last shift of a block the main buffer refills on the same edge,
    // from the shadow if it holds a block, else straight from block_in.
    always_comb begin
        main_load      = (state == ST_WAIT_BLOCK) && block_valid;
        main_src       = block_in;
        main_src_words = blk_words;
        shadow_load    = 1'b0;
        shadow_clear   = 1'b0;
        if (state == ST_DUMP && exhaust) begin
            if (!shadow_empty) begin
                main_load      = 1'b1;
                main_src       = shadow_data;
                main_src_words = shadow_words;
                shadow_clear   = 1'b1;
            end else if (blk_fire) begin
                main_load = 1'b1;
            end
        end
        if (state == ST_DUMP && blk_fire && !main_load) begin
            shadow_load = 1'b1;
        end
    end

    output_shift_buffer #(.W(W), .RATE_MAX(RATE_MAX)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load       (shadow_load),
        .load_data  (block_in),
        .load_words (blk_words),
        .shift      (1'b0),
        .clear      (shadow_clear),
        .data       (shadow_data),
        .words      (shadow_words),
        .empty      (shadow_empty)
    );
`else
    assign block_ready = (state == ST_WAIT_BLOCK);

    always_comb begin
        main_load      = (state == ST_WAIT_BLOCK) && block_valid;
        main_src       = block_in;
        main_src_words = blk_words;
    end
`endif

    output_shift_buffer #(.W(W), .RATE_MAX(RATE_MAX)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .load_data  (main_src),
        .load_words (main_src_words),
        .shift      (fire),
        .clear      (1'b0),
        .data       (main_data),
        .words      (main_words),
        .empty      (main_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            mode         <= MODE_SHAKE128;
            bits_to_load <= 32'd0;
            bits_to_emit <= 32'd0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode         <= keccak_mode_t'(mode_in);
                        bits_to_load <= start_size;
                        bits_to_emit <= start_size;
                        if (start_size == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_WAIT_BLOCK;
                        end
                    end
                end
                ST_WAIT_BLOCK: begin
                    if (block_valid) begin
                        bits_to_load <= sat_sub(bits_to_load, rate);
                        state        <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    // Only reachable with the shadow buffer present.
                    if (blk_fire) begin
                        bits_to_load <= sat_sub(bits_to_load, rate);
                    end
                    if (fire) begin
                        bits_to_emit <= sat_sub(bits_to_emit, 32'(W));
                        if (final_word) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else if (main_words == 8'd1 && !main_load) begin
                            state <= ST_WAIT_BLOCK;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_dump_stage.sv
// Directed bench for squeeze_dump_stage (W=64). Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
module tb_squeeze_dump_stage;

    localparam int W  = 64;
    localparam int RM = 1344;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode_in = 2'b00;
    logic [31:0]   output_size_in = 32'd0;
    logic [RM-1:0] block_in = '0;
    logic          block_valid = 1'b0;
    logic          block_ready;
    logic          need_block;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          last_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [RM-1:0] blk_a;
    logic [RM-1:0] blk_b;

    always #5 clk = ~clk;

    squeeze_dump_stage #(.W(W), .RATE_MAX(RM)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode_in        (mode_in),
        .output_size_in (output_size_in),
        .block_in       (block_in),
        .block_valid    (block_valid),
        .block_ready    (block_ready),
        .need_block     (need_block),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .last_out       (last_out),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte i of the block = seed + i.
    function automatic logic [RM-1:0] make_block(input logic [7:0] seed);
        logic [RM-1:0] b;
        b = '0;
        for (int i = 0; i < RM / 8; i++) begin
            b[8*i +: 8] = 8'(seed + 8'(i));
        end
        return b;
    endfunction

    task automatic start_job(input logic [1:0] m, input logic [31:0] size);
        start          = 1'b1;
        mode_in        = m;
        output_size_in = size;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic give_block(input logic [RM-1:0] blk);
        int guard;
        guard = 0;
        while (!block_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("block_ready_wait", 64'(block_ready), 64'd1);
        block_valid = 1'b1;
        block_in    = blk;
        @(negedge clk);
        block_valid = 1'b0;
    endtask

    // Consume nw words of blk; rem0 = output bits still owed before word 0.
    task automatic expect_words(input logic [RM-1:0] blk, input int nw,
                                input int rem0, input bit bp, input string tag);
        int rem;
        int stalls;
        logic [63:0] exp;
        rem = rem0;
        for (int k = 0; k < nw; k++) begin
            exp = blk[64*k +: 64];
            if (rem < 64) exp = exp & ((64'd1 << rem) - 64'd1);
            stalls = bp ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s <= stalls; s++) begin
                ready_in = (s == stalls);
                chk({tag, "_valid"}, 64'(valid_out), 64'd1);
                chk({tag, "_data"}, data_out, exp);
                chk({tag, "_last"}, 64'(last_out), 64'(rem <= 64));
                @(negedge clk);
            end
            rem = rem - 64;
        end
        ready_in = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_valid_low"}, 64'(valid_out), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_block_ready", 64'(block_ready), 64'd0);
        chk("rst_need_block", 64'(need_block), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_last_out", 64'(last_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // SHAKE128, 256 bits, one block
        blk_a = make_block(8'h00);
        start_job(2'b00, 32'd256);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_need_block", 64'(need_block), 64'd1);
        chk("t1_block_ready", 64'(block_ready), 64'd1);
        give_block(blk_a);
        chk("t1_need_block_low", 64'(need_block), 64'd0);
        chk("t1_word0_lit", data_out, 64'h0706050403020100);
        expect_words(blk_a, 4, 256, 1'b0, "t1");
        expect_done("t1");

        // SHAKE256, 1100 bits: 17 words, refill, 12-bit tail word
        blk_b = make_block(8'h80);
        start_job(2'b01, 32'd1100);
        give_block(blk_a);
        chk("t2_need_block_mid", 64'(need_block), 64'd1);
        expect_words(blk_a, 17, 1100, 1'b0, "t2a");
        chk("t2_wait_valid", 64'(valid_out), 64'd0);
        chk("t2_wait_need", 64'(need_block), 64'd1);
        chk("t2_wait_ready", 64'(block_ready), 64'd1);
        give_block(blk_b);
        chk("t2_tail_lit", data_out, 64'h0000000000000180);
        expect_words(blk_b, 1, 12, 1'b0, "t2b");
        expect_done("t2");

        // SHA3-512 ignores the requested size
        blk_a = make_block(8'h10);
        start_job(2'b11, 32'd12345);
        give_block(blk_a);
        chk("t3_need_block", 64'(need_block), 64'd0);
        expect_words(blk_a, 8, 512, 1'b0, "t3");
        expect_done("t3");

        // Size 0: immediate done, nothing else
        start_job(2'b00, 32'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_valid", 64'(valid_out), 64'd0);
        chk("t4_block_ready", 64'(block_ready), 64'd0);
        @(negedge clk);
        chk("t4_done_pulse", 64'(done), 64'd0);

        // SHAKE128, 2688 bits, random backpressure, two blocks
        blk_a = make_block(8'h21);
        blk_b = make_block(8'h95);
        start_job(2'b00, 32'd2688);
        give_block(blk_a);
        expect_words(blk_a, 21, 2688, 1'b1, "t5a");
        chk("t5_bubble_valid", 64'(valid_out), 64'd0);
        chk("t5_bubble_ready", 64'(block_ready), 64'd1);
        give_block(blk_b);
        expect_words(blk_b, 21, 1344, 1'b1, "t5b");
        expect_done("t5");

        // Reset mid-DUMP, then a fresh job
        blk_a = make_block(8'h00);
        start_job(2'b00, 32'd256);
        give_block(blk_a);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk("t6_pre_valid", 64'(valid_out), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(valid_out), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_data", data_out, 64'd0);
        chk("t6_rst_last", 64'(last_out), 64'd0);
        chk("t6_rst_need", 64'(need_block), 64'd0);
        chk("t6_rst_ready", 64'(block_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        blk_b = make_block(8'h40);
        start_job(2'b01, 32'd64);
        give_block(blk_b);
        chk("t6_new_lit", data_out, 64'h4746454443424140);
        expect_words(blk_b, 1, 64, 1'b0, "t6");
        expect_done("t6");

`ifdef SQUEEZE_DUMP_DOUBLE_BUFFER_EN
        // Shadow buffer: second block prefetched, 42 words back to back
        blk_a = make_block(8'h33);
        blk_b = make_block(8'hc7);
        start_job(2'b00, 32'd2688);
        give_block(blk_a);
        give_block(blk_b);
        chk("t7_need_low", 64'(need_block), 64'd0);
        expect_words(blk_a, 21, 2688, 1'b0, "t7a");
        ready_in = 1'b1;
        expect_words(blk_b, 21, 1344, 1'b0, "t7b");
        expect_done("t7");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
